// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the parametrised data memory.
package dmem_pkg;

  localparam int unsigned DMEM_DATA_WIDTH = 8;
  localparam int unsigned DMEM_ADDR_WIDTH = 8;
  localparam int unsigned DMEM_LATENCY    = 5;
  localparam int unsigned DMEM_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

endpackage

// File: rtl/dmem_latency_counter.sv
// Loadable down-counter that saturates at zero; zero_c flags the final access cycle.
module dmem_latency_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero_c
);

  assign zero_c = (count == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero_c) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/param_data_memory.sv
// Parametrised single-port data memory with request/busywait handshake and fixed latency.
// Optional DMEM_PARITY_EN stores an even-parity bit per word and reports parity_err on reads.
module param_data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int unsigned LATENCY    = DMEM_LATENCY
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writedata,
`ifdef DMEM_PARITY_EN
  output logic                  parity_err,
`endif
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  busywait
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_WIDTH = DMEM_CNT_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef DMEM_PARITY_EN
  logic                  mem_parity [DEPTH];
`endif

  state_t                state;
  op_t                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  cnt_zero;
  logic                  req_valid;
  logic                  accept;
  logic                  fire;

  // read and write together is not a request
  assign req_valid = read ^ write;
  assign accept    = (state == ST_IDLE) && req_valid;
  assign fire      = (state == ST_ACCESS) && cnt_zero;

  // Raised in the request cycle itself so the requester loses no cycle; forced low in reset.
  assign busywait  = reset && (accept || (state == ST_ACCESS));

  dmem_latency_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (CNT_WIDTH'(LATENCY - 1)),
    .dec        (state == ST_ACCESS),
    .count      (cnt),
    .zero_c     (cnt_zero)
  );

  // Control FSM, request latching and registered read data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_READ;
      addr_q   <= '0;
      data_q   <= '0;
      readdata <= '0;
`ifdef DMEM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state  <= ST_ACCESS;
            addr_q <= address;
            data_q <= writedata;
            op_q   <= write ? OP_WRITE : OP_READ;
          end
        end
        ST_ACCESS: begin
          if (cnt_zero) begin
            state <= ST_DONE;
            if (op_q == OP_READ) begin
              readdata <= mem[addr_q];
`ifdef DMEM_PARITY_EN
              parity_err <= (^mem[addr_q]) ^ mem_parity[addr_q];
`endif
            end
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Storage: cleared on reset, so a write aborted by reset never lands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
`ifdef DMEM_PARITY_EN
        mem_parity[i] <= 1'b0;
`endif
      end
    end else if (fire && (op_q == OP_WRITE)) begin
      mem[addr_q] <= data_q;
`ifdef DMEM_PARITY_EN
      mem_parity[addr_q] <= ^data_q;
`endif
    end
  end

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_param_data_memory.sv
// Scoreboard bench for param_data_memory: driver queues expected completions, monitor checks them.
module tb_param_data_memory;
  import dmem_pkg::*;

  localparam int unsigned LAT = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [7:0] address = 8'h00;
  logic [7:0] writedata = 8'h00;
  logic [7:0] readdata;
  logic       busywait;
`ifdef DMEM_PARITY_EN
  logic       parity_err;
`endif

  param_data_memory #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .LATENCY    (LAT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .read       (read),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
`ifdef DMEM_PARITY_EN
    .parity_err (parity_err),
`endif
    .readdata   (readdata),
    .busywait   (busywait)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       is_read;
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t exp_q [$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;
  int   busy_cnt = 0;
  bit   prev_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Completion monitor: a busywait fall outside reset marks the DONE cycle.
  always @(negedge clock) begin
    if (!reset) begin
      busy_cnt  = 0;
      prev_busy = 0;
    end else begin
      if (busywait) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check(e.is_read ? "busy_cycles_read" : "busy_cycles_write", 32'(busy_cnt), 32'(LAT + 1));
          check(e.is_read ? "readdata_after_read" : "readdata_held_after_write", 32'(readdata), 32'(e.data));
`ifdef DMEM_PARITY_EN
          check("parity_err", 32'(parity_err), 32'(e.par));
`endif
        end
        busy_cnt = 0;
      end
      prev_busy = busywait;
    end
  end

  task automatic access(input logic rd, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp_rdata, input logic exp_par, input bit mutate);
    bit done;
    @(posedge clock); #1;
    read      = rd;
    write     = !rd;
    address   = addr;
    writedata = wdata;
    exp_q.push_back('{is_read: rd, data: exp_rdata, par: exp_par});
    done = 0;
    for (int c = 0; c < 64; c++) begin
      @(posedge clock); #1;
      if (mutate && c == 0) begin
        address   = addr + 8'd1;
        writedata = 8'hFF;
      end
      if (!busywait) begin
        done = 1;
        break;
      end
    end
    read  = 1'b0;
    write = 1'b0;
    if (!done) check("access_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // reset held with a read pending
    read = 1'b1;
    #23;
    check("reset_busywait", 32'(busywait), 32'd0);
    check("reset_readdata", 32'(readdata), 32'd0);
    read = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #2;
    check("post_reset_busywait", 32'(busywait), 32'd0);
    check("post_reset_readdata", 32'(readdata), 32'd0);

    access(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 0);
    access(1'b1, 8'h7F, 8'h00, 8'h00, 1'b0, 0);
    access(1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 0);

    access(1'b0, 8'h10, 8'hA5, 8'h00, 1'b0, 0);
    access(1'b1, 8'h10, 8'h00, 8'hA5, 1'b0, 0);

    // read and write together: ignored
    @(posedge clock); #1;
    read = 1'b1; write = 1'b1; address = 8'h20; writedata = 8'h55;
    repeat (3) begin
      #2;
      check("illegal_busywait", 32'(busywait), 32'd0);
      @(posedge clock); #1;
    end
    read = 1'b0; write = 1'b0;
    access(1'b1, 8'h20, 8'h00, 8'h00, 1'b0, 0);

    // inputs changed during ACCESS must not matter
    access(1'b0, 8'h40, 8'h3C, 8'h00, 1'b0, 1);
    access(1'b1, 8'h40, 8'h00, 8'h3C, 1'b0, 0);
    access(1'b1, 8'h41, 8'h00, 8'h00, 1'b0, 0);

    // reset in the 3rd ACCESS cycle aborts the write
    @(posedge clock); #1;
    write = 1'b1; address = 8'h05; writedata = 8'h77;
    @(posedge clock);
    @(posedge clock);
    @(posedge clock); #1;
    check("busy_before_abort", 32'(busywait), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busywait", 32'(busywait), 32'd0);
    check("abort_state_idle", 32'(dut.state), 32'(ST_IDLE));
    check("abort_readdata", 32'(readdata), 32'd0);
    write = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    access(1'b1, 8'h05, 8'h00, 8'h00, 1'b0, 0);
    access(1'b1, 8'h10, 8'h00, 8'h00, 1'b0, 0);

    // boundary addresses
    access(1'b0, 8'hFF, 8'h5A, 8'h00, 1'b0, 0);
    access(1'b1, 8'hFF, 8'h00, 8'h5A, 1'b0, 0);
    access(1'b0, 8'h00, 8'hC3, 8'h5A, 1'b0, 0);
    access(1'b1, 8'h00, 8'h00, 8'hC3, 1'b0, 0);

`ifdef DMEM_PARITY_EN
    access(1'b0, 8'h30, 8'h01, 8'hC3, 1'b0, 0);
    access(1'b1, 8'h30, 8'h00, 8'h01, 1'b0, 0);
    @(posedge clock); #1;
    dut.mem_parity[8'h30] = ~dut.mem_parity[8'h30];
    access(1'b1, 8'h30, 8'h00, 8'h01, 1'b1, 0);
`endif

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/param_data_memory.md
Name: param_data_memory

Overview:
- Parametrised successor to the 256x8 CPU data memory: configurable word width and depth, latency counted in clock cycles, and a clean request/busywait handshake with a one-cycle completion state.
- Sits between the CPU datapath (or a later cache) and backing storage.
- Serves single-word reads and writes; the CPU stalls while busywait is high.

Parameters:
DATA_WIDTH, 8, bits per memory word.
ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH words.
LATENCY, 5, clock cycles from request acceptance to completion edge; legal range 1..255.

Ports:
clock  input  1  system clock, all state changes on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
read  input  1  read request, level, held by requester until busywait falls.
write  input  1  write request, level, held by requester until busywait falls.
address  input  ADDR_WIDTH  word address.
writedata  input  DATA_WIDTH  write data.
readdata  output  DATA_WIDTH  registered read data.
busywait  output  1  stall indication to requester.

Behaviour:
- Reset (reset low, asynchronous):
  - state to IDLE; counter to 0.
  - readdata = 0, busywait = 0.
  - All memory words cleared to 0.
  - An in-flight write is aborted and the target word is not written.
  - Outputs stay at reset values while reset is held low.
- A request is valid when read XOR write. read=write=1 is illegal and treated as no request: busywait stays 0 and memory is untouched.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - busywait = valid request (combinational, so it rises in the same cycle as the request, with no lost cycle).
  - At posedge with a valid request: latch address, writedata and op; load counter with LATENCY-1; go to ACCESS.
- ACCESS:
  - busywait = 1.
  - While counter != 0: decrement counter.
  - At posedge with counter == 0, perform the latched op:
    - read: readdata <= mem[latched addr].
    - write: mem[latched addr] <= latched data.
  - Then go to DONE.
- DONE:
  - busywait = 0 for exactly one cycle; requests are ignored (no re-trigger while the requester drops its request).
  - Next state IDLE.
- Latency:
  - busywait is high for LATENCY+1 cycles: the acceptance cycle plus LATENCY cycles in ACCESS.
  - Read data is valid on readdata in the DONE cycle and stays held until the next completed read or reset.
- readdata is not changed by writes, nor by requests that are dropped before acceptance.
- Input changes during ACCESS (address, writedata, read, write) have no effect, because inputs are latched at acceptance.
- Back-to-back: a request still high in the cycle after DONE is accepted as a new access. The requester must drop its request on busywait falling to avoid a duplicate access.
- Address wrap: none. All 2**ADDR_WIDTH addresses are valid; width rules are exact with no truncation.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit, computed on write and cleared to 0 on reset.
  - Adds output port parity_err (1 bit), reset 0.
  - On a completed read, parity_err is set to the parity mismatch of the word read, registered together with readdata; it stays valid until the next read completes.
- When undefined: no parity storage and no parity_err port; behaviour is otherwise identical.

Decomposition:
- Shared package dmem_pkg:
  - FSM state typedef (IDLE/ACCESS/DONE).
  - Op enum (OP_READ, OP_WRITE).
  - Default width constants.
- One natural sub-module, dmem_latency_counter: loadable down-counter with a zero flag, width 8.
- Storage array and FSM live in the top module.

Test Plan:
- Reset low with busywait/readdata probed, then release:
  - readdata=0, busywait=0.
  - Read of addresses 0x00, 0x7F and 0xFF each returns 0x00.
- Write 0xA5 to 0x10 (LATENCY=5), then read 0x10:
  - busywait high 6 cycles per access.
  - readdata=0xA5 in the DONE cycle of the read.
- read=write=1 at address 0x20 with writedata 0x55:
  - busywait stays 0; a later read of 0x20 returns 0x00.
- Write 0x3C to 0x40 accepted; change address to 0x41 and writedata to 0xFF during ACCESS:
  - mem[0x40]=0x3C, mem[0x41]=0x00.
- Write 0x77 to 0x05; pull reset low in the 3rd ACCESS cycle:
  - busywait=0 immediately, state IDLE.
  - A later read of 0x05 returns 0x00.
- DMEM_PARITY_EN defined:
  - Write 0x01 then read it: parity_err=0.
  - Force a stored parity-bit flip via hierarchical access, then read: parity_err=1.
